// File: rtl/scr1_ahb_mem_pkg.sv
// Shared AHB-Lite encodings for the SCR1 dual-port simulation memory.
package scr1_ahb_mem_pkg;

  localparam int SCR1_AHB_WIDTH = 32;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;

  localparam logic HRESP_OKAY = 1'b0;

endpackage

// File: rtl/scr1_mem_stall_gen.sv
// Per-port wait-state generator: a 32-bit pattern rotated right every clock,
// whose bit 0 gates hready while a data phase is pending.
module scr1_mem_stall_gen
  import scr1_ahb_mem_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SCR1_AHB_WIDTH-1:0] stall_in,
  input  logic                      pending,
  output logic                      hready
);

  logic [SCR1_AHB_WIDTH-1:0] pattern;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern <= stall_in;
    end else begin
      pattern <= {pattern[0], pattern[SCR1_AHB_WIDTH-1:1]};
    end
  end

  // An all-zero pattern means "never stall", so bit 0 alone is not enough.
  assign hready = ~pending | (pattern == '0) | pattern[0];

endmodule

// File: rtl/scr1_ahb_dual_mem.sv
// Dual AHB-Lite slave simulation memory (read-only imem, read/write dmem) over one
// shared byte array; contents are not reset and are preloaded by the harness.
// Optional memory-mapped IRQ register enabled by defining SCR1_MEM_IRQ_EN.
module scr1_ahb_dual_mem
  import scr1_ahb_mem_pkg::*;
#(
  parameter int          SCR1_MEM_POWER_SIZE = 16,
  parameter int          SCR1_IRQ_LINES_NUM  = 16,
  parameter logic [31:0] SCR1_IRQ_ADDR       = 32'hF000_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SCR1_AHB_WIDTH-1:0] imem_req_ack_stall_in,
  input  logic [SCR1_AHB_WIDTH-1:0] dmem_req_ack_stall_in,
  input  logic [3:0]                imem_hprot,
  input  logic [2:0]                imem_hburst,
  input  logic [2:0]                imem_hsize,
  input  logic [1:0]                imem_htrans,
  input  logic [SCR1_AHB_WIDTH-1:0] imem_haddr,
  output logic                      imem_hready,
  output logic [SCR1_AHB_WIDTH-1:0] imem_hrdata,
  output logic                      imem_hresp,
  input  logic [3:0]                dmem_hprot,
  input  logic [2:0]                dmem_hburst,
  input  logic [2:0]                dmem_hsize,
  input  logic [1:0]                dmem_htrans,
  input  logic [SCR1_AHB_WIDTH-1:0] dmem_haddr,
  input  logic                      dmem_hwrite,
  input  logic [SCR1_AHB_WIDTH-1:0] dmem_hwdata,
  output logic                      dmem_hready,
  output logic [SCR1_AHB_WIDTH-1:0] dmem_hrdata,
  output logic                      dmem_hresp
`ifdef SCR1_MEM_IRQ_EN
  ,
  output logic [SCR1_IRQ_LINES_NUM-1:0] irq_lines
`endif
);

  localparam int AW = SCR1_MEM_POWER_SIZE;

  logic [7:0] mem [0:(1<<AW)-1];

  logic                      imem_pend;
  logic                      imem_accept;
  logic [AW-1:0]             imem_addr_q;
  logic [SCR1_AHB_WIDTH-1:0] imem_word;
  logic [SCR1_AHB_WIDTH-1:0] imem_rdata_q;

  logic                      dmem_pend;
  logic                      dmem_accept;
  logic                      dmem_done;
  logic                      dmem_write_q;
  logic                      dmem_irq_sel;
  logic [AW-1:0]             dmem_addr_q;
  logic [2:0]                dmem_size_q;
  logic [3:0]                dmem_be;
  logic [SCR1_AHB_WIDTH-1:0] dmem_word;
  logic [SCR1_AHB_WIDTH-1:0] dmem_rd;
  logic [SCR1_AHB_WIDTH-1:0] dmem_rdata_q;

  scr1_mem_stall_gen i_imem_stall (
    .clk      (clk),
    .rst      (rst),
    .stall_in (imem_req_ack_stall_in),
    .pending  (imem_pend),
    .hready   (imem_hready)
  );

  scr1_mem_stall_gen i_dmem_stall (
    .clk      (clk),
    .rst      (rst),
    .stall_in (dmem_req_ack_stall_in),
    .pending  (dmem_pend),
    .hready   (dmem_hready)
  );

  assign imem_accept = imem_hready & ((imem_htrans == HTRANS_NONSEQ) | (imem_htrans == HTRANS_SEQ));
  assign dmem_accept = dmem_hready & ((dmem_htrans == HTRANS_NONSEQ) | (dmem_htrans == HTRANS_SEQ));
  assign dmem_done   = dmem_pend & dmem_hready;

  assign imem_word = {mem[{imem_addr_q[AW-1:2], 2'd3}], mem[{imem_addr_q[AW-1:2], 2'd2}],
                      mem[{imem_addr_q[AW-1:2], 2'd1}], mem[{imem_addr_q[AW-1:2], 2'd0}]};
  assign dmem_word = {mem[{dmem_addr_q[AW-1:2], 2'd3}], mem[{dmem_addr_q[AW-1:2], 2'd2}],
                      mem[{dmem_addr_q[AW-1:2], 2'd1}], mem[{dmem_addr_q[AW-1:2], 2'd0}]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_pend    <= 1'b0;
      imem_addr_q  <= '0;
      imem_rdata_q <= '0;
    end else if (imem_hready) begin
      imem_pend <= imem_accept;
      if (imem_accept) imem_addr_q <= imem_haddr[AW-1:0];
      if (imem_pend) imem_rdata_q <= imem_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_pend    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_size_q  <= '0;
      dmem_write_q <= 1'b0;
      dmem_rdata_q <= '0;
    end else begin
      if (dmem_hready) begin
        dmem_pend <= dmem_accept;
        if (dmem_accept) begin
          dmem_addr_q  <= dmem_haddr[AW-1:0];
          dmem_size_q  <= dmem_hsize;
          dmem_write_q <= dmem_hwrite;
        end
      end
      if (dmem_done & ~dmem_write_q) dmem_rdata_q <= dmem_rd;
    end
  end

  // Read data is combinational in the completing cycle so a same-edge write
  // cannot leak into it (read-before-write between the two ports).
  assign imem_hrdata = (imem_pend & imem_hready) ? imem_word : imem_rdata_q;
  assign dmem_hrdata = (dmem_done & ~dmem_write_q) ? dmem_rd : dmem_rdata_q;
  assign imem_hresp  = HRESP_OKAY;
  assign dmem_hresp  = HRESP_OKAY;

  always_comb begin
    dmem_be = 4'b0000;
    case (dmem_size_q)
      HSIZE_BYTE: dmem_be[dmem_addr_q[1:0]] = 1'b1;
      HSIZE_HALF: dmem_be = dmem_addr_q[1] ? 4'b1100 : 4'b0011;
      default:    dmem_be = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (dmem_done & dmem_write_q & ~dmem_irq_sel) begin
      for (int i = 0; i < 4; i++) begin
        if (dmem_be[i]) mem[{dmem_addr_q[AW-1:2], 2'(i)}] <= dmem_hwdata[8*i +: 8];
      end
    end
  end

`ifdef SCR1_MEM_IRQ_EN
  logic irq_sel_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_sel_q <= 1'b0;
    end else if (dmem_accept) begin
      irq_sel_q <= (dmem_haddr == SCR1_IRQ_ADDR);
    end
  end

  // Non-word writes to the IRQ address are dropped rather than hitting the array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_lines <= '0;
    end else if (dmem_done & dmem_write_q & irq_sel_q & (dmem_size_q == HSIZE_WORD)) begin
      irq_lines <= dmem_hwdata[SCR1_IRQ_LINES_NUM-1:0];
    end
  end

  assign dmem_irq_sel = irq_sel_q;
  assign dmem_rd      = irq_sel_q ? SCR1_AHB_WIDTH'(irq_lines) : dmem_word;
`else
  logic unused_irq_cfg;

  assign dmem_irq_sel   = 1'b0;
  assign dmem_rd        = dmem_word;
  assign unused_irq_cfg = ^SCR1_IRQ_ADDR ^ SCR1_IRQ_LINES_NUM[0];
`endif

  logic unused_inputs;

  assign unused_inputs = ^{imem_hprot, imem_hburst, imem_hsize, imem_haddr[SCR1_AHB_WIDTH-1:AW],
                           dmem_hprot, dmem_hburst, dmem_haddr[SCR1_AHB_WIDTH-1:AW]};

endmodule

// File: tb/tb_scr1_ahb_dual_mem.sv
// Randomised self-checking bench for scr1_ahb_dual_mem against a byte-array reference model.
// Define SCR1_MEM_IRQ_EN to also exercise the IRQ register.
module tb_scr1_ahb_dual_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_req_ack_stall_in = '0;
  logic [31:0] dmem_req_ack_stall_in = '0;
  logic [3:0]  imem_hprot = '0;
  logic [2:0]  imem_hburst = '0;
  logic [2:0]  imem_hsize = 3'd2;
  logic [1:0]  imem_htrans = '0;
  logic [31:0] imem_haddr = '0;
  logic        imem_hready;
  logic [31:0] imem_hrdata;
  logic        imem_hresp;
  logic [3:0]  dmem_hprot = '0;
  logic [2:0]  dmem_hburst = '0;
  logic [2:0]  dmem_hsize = 3'd2;
  logic [1:0]  dmem_htrans = '0;
  logic [31:0] dmem_haddr = '0;
  logic        dmem_hwrite = 1'b0;
  logic [31:0] dmem_hwdata = '0;
  logic        dmem_hready;
  logic [31:0] dmem_hrdata;
  logic        dmem_hresp;
`ifdef SCR1_MEM_IRQ_EN
  logic [15:0] irq_lines;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] ipat;
  logic [31:0] dpat;
  logic [31:0] ncyc;
  logic [7:0]  ref_mem [0:65535];

  scr1_ahb_dual_mem dut (
    .clk                   (clk),
    .rst                   (rst),
    .imem_req_ack_stall_in (imem_req_ack_stall_in),
    .dmem_req_ack_stall_in (dmem_req_ack_stall_in),
    .imem_hprot            (imem_hprot),
    .imem_hburst           (imem_hburst),
    .imem_hsize            (imem_hsize),
    .imem_htrans           (imem_htrans),
    .imem_haddr            (imem_haddr),
    .imem_hready           (imem_hready),
    .imem_hrdata           (imem_hrdata),
    .imem_hresp            (imem_hresp),
    .dmem_hprot            (dmem_hprot),
    .dmem_hburst           (dmem_hburst),
    .dmem_hsize            (dmem_hsize),
    .dmem_htrans           (dmem_htrans),
    .dmem_haddr            (dmem_haddr),
    .dmem_hwrite           (dmem_hwrite),
    .dmem_hwdata           (dmem_hwdata),
    .dmem_hready           (dmem_hready),
    .dmem_hrdata           (dmem_hrdata),
    .dmem_hresp            (dmem_hresp)
`ifdef SCR1_MEM_IRQ_EN
    ,
    .irq_lines             (irq_lines)
`endif
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; stall bit for a cycle is pattern[ncyc mod 32].
  always @(posedge clk or posedge rst) begin
    if (rst) ncyc <= '0;
    else     ncyc <= ncyc + 1;
  end

  function automatic logic [31:0] model_word(input logic [31:0] addr);
    int b;
    b = {16'h0, addr[15:2], 2'b00};
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  task automatic model_write(input logic [2:0] sz, input logic [31:0] addr, input logic [31:0] d);
    int b;
    bit en;
    b = {16'h0, addr[15:2], 2'b00};
    for (int l = 0; l < 4; l++) begin
      if (sz == 3'd0)      en = (l == int'(addr[1:0]));
      else if (sz == 3'd1) en = ((l / 2) == int'(addr[1]));
      else                 en = 1'b1;
      if (en) ref_mem[b+l] = d[8*l +: 8];
    end
  endtask

  task automatic do_reset(input logic [31:0] ip, input logic [31:0] dp);
    ipat = ip;
    dpat = dp;
    imem_req_ack_stall_in = ip;
    dmem_req_ack_stall_in = dp;
    imem_htrans = 2'b00;
    dmem_htrans = 2'b00;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Single transfers start and end one time unit after a rising edge.
  task automatic dmem_xfer(input logic wr, input logic [2:0] sz, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata,
                           output int waits, output int bad);
    logic exp_rdy;
    bad = 0;
    waits = 0;
    dmem_htrans = 2'b10;
    dmem_haddr = addr;
    dmem_hsize = sz;
    dmem_hwrite = wr;
    @(posedge clk); #1;
    dmem_htrans = 2'b00;
    dmem_hwdata = wdata;
    while (waits < 64) begin
      exp_rdy = (dpat == 32'h0) || dpat[ncyc[4:0]];
      if (dmem_hready !== exp_rdy) bad++;
      if (dmem_hresp !== 1'b0) bad++;
      if (dmem_hready === 1'b1) break;
      waits++;
      @(posedge clk); #1;
    end
    if (waits >= 64) bad++;
    rdata = dmem_hrdata;
    @(posedge clk); #1;
  endtask

  task automatic imem_xfer(input logic [31:0] addr, output logic [31:0] rdata,
                           output int waits, output int bad);
    logic exp_rdy;
    bad = 0;
    waits = 0;
    imem_htrans = 2'b10;
    imem_haddr = addr;
    @(posedge clk); #1;
    imem_htrans = 2'b00;
    while (waits < 64) begin
      exp_rdy = (ipat == 32'h0) || ipat[ncyc[4:0]];
      if (imem_hready !== exp_rdy) bad++;
      if (imem_hresp !== 1'b0) bad++;
      if (imem_hready === 1'b1) break;
      waits++;
      @(posedge clk); #1;
    end
    if (waits >= 64) bad++;
    rdata = imem_hrdata;
    @(posedge clk); #1;
  endtask

  task automatic dwrite(input logic [2:0] sz, input logic [31:0] addr, input logic [31:0] d,
                        output int bad);
    logic [31:0] rd;
    int w;
    dmem_xfer(1'b1, sz, addr, d, rd, w, bad);
    model_write(sz, addr, d);
  endtask

  task automatic test_reset;
    do_reset(32'h0, 32'h0);
    checks++; if (imem_hready !== 1'b1) begin errors++; $display("[TB] FAIL reset_imem_hready: got %b expected 1", imem_hready); end
    checks++; if (dmem_hready !== 1'b1) begin errors++; $display("[TB] FAIL reset_dmem_hready: got %b expected 1", dmem_hready); end
    checks++; if (imem_hrdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_imem_hrdata: got %h expected 0", imem_hrdata); end
    checks++; if (dmem_hrdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_dmem_hrdata: got %h expected 0", dmem_hrdata); end
    checks++; if ({imem_hresp, dmem_hresp} !== 2'b00) begin errors++; $display("[TB] FAIL reset_hresp: got %b expected 00", {imem_hresp, dmem_hresp}); end
`ifdef SCR1_MEM_IRQ_EN
    checks++; if (irq_lines !== 16'h0) begin errors++; $display("[TB] FAIL reset_irq: got %h expected 0", irq_lines); end
`endif
  endtask

  task automatic test_word_write_fetch;
    logic [31:0] rd;
    int w, bad;
    do_reset(32'h0, 32'h0);
    dwrite(3'd2, 32'h100, 32'hDEADBEEF, bad);
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL word_write_handshake: got %0d bad cycles expected 0", bad); end
    imem_xfer(32'h100, rd, w, bad);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL fetch_data: got %h expected deadbeef", rd); end
    checks++; if (w !== 0) begin errors++; $display("[TB] FAIL fetch_waits: got %0d expected 0", w); end
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL fetch_handshake: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_byte_half;
    logic [31:0] rd;
    int w, bad, b2;
    dwrite(3'd2, 32'h200, 32'h0, bad);
    dwrite(3'd0, 32'h202, 32'h11AA2233, b2);
    bad += b2;
    dmem_xfer(1'b0, 3'd2, 32'h200, 32'h0, rd, w, b2);
    bad += b2;
    checks++; if (rd !== 32'h00AA0000) begin errors++; $display("[TB] FAIL byte_write: got %h expected 00aa0000", rd); end
    dwrite(3'd2, 32'h204, 32'h9ABC5678, b2);
    bad += b2;
    dwrite(3'd1, 32'h206, 32'h1234FFFF, b2);
    bad += b2;
    dmem_xfer(1'b0, 3'd2, 32'h204, 32'h0, rd, w, b2);
    bad += b2;
    checks++; if (rd !== 32'h12345678) begin errors++; $display("[TB] FAIL half_write: got %h expected 12345678", rd); end
    dwrite(3'd1, 32'h201, 32'hBEEF7766, b2);
    bad += b2;
    dmem_xfer(1'b0, 3'd0, 32'h203, 32'h0, rd, w, b2);
    bad += b2;
    checks++; if (rd !== 32'h00AA7766) begin errors++; $display("[TB] FAIL misaligned_half: got %h expected 00aa7766", rd); end
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL byte_half_handshake: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_read_before_write;
    logic [31:0] rd;
    int w, bad;
    dwrite(3'd2, 32'h400, 32'h11111111, bad);
    imem_htrans = 2'b10;
    imem_haddr  = 32'h400;
    dmem_htrans = 2'b10;
    dmem_haddr  = 32'h400;
    dmem_hsize  = 3'd2;
    dmem_hwrite = 1'b1;
    @(posedge clk); #1;
    imem_htrans = 2'b00;
    dmem_htrans = 2'b00;
    dmem_hwdata = 32'h22222222;
    checks++; if (imem_hrdata !== 32'h11111111) begin errors++; $display("[TB] FAIL read_before_write_old: got %h expected 11111111", imem_hrdata); end
    @(posedge clk); #1;
    model_write(3'd2, 32'h400, 32'h22222222);
    imem_xfer(32'h400, rd, w, bad);
    checks++; if (rd !== 32'h22222222) begin errors++; $display("[TB] FAIL read_before_write_new: got %h expected 22222222", rd); end
  endtask

  task automatic test_back_to_back;
    logic        pend;
    logic        exp_rdy;
    logic [31:0] paddr;
    int idx, got, stalls, bad, b2;
    do_reset(32'h0, 32'h55555555);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      dwrite(3'd2, 32'h300 + 4*i, $urandom, b2);
      bad += b2;
    end
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL b2b_prefill_handshake: got %0d bad cycles expected 0", bad); end
    pend = 1'b0; paddr = '0; idx = 0; got = 0; stalls = 0; bad = 0;
    for (int cyc = 0; cyc < 200 && got < 16; cyc++) begin
      exp_rdy = !pend || dpat[ncyc[4:0]];
      if (dmem_hready !== exp_rdy) bad++;
      if (pend && dmem_hready === 1'b1) begin
        checks++;
        if (dmem_hrdata !== model_word(paddr)) begin
          errors++;
          $display("[TB] FAIL b2b_read @%h: got %h expected %h", paddr, dmem_hrdata, model_word(paddr));
        end
        got++;
        pend = 1'b0;
      end else if (pend) begin
        stalls++;
      end
      if (dmem_hready === 1'b1 && idx < 16) begin
        dmem_htrans = 2'b10;
        dmem_haddr  = 32'h300 + 4*idx;
        dmem_hsize  = 3'd2;
        dmem_hwrite = 1'b0;
        paddr = dmem_haddr;
        pend = 1'b1;
        idx++;
      end else if (dmem_hready === 1'b1) begin
        dmem_htrans = 2'b00;
      end
      @(posedge clk); #1;
    end
    dmem_htrans = 2'b00;
    checks++; if (got !== 16) begin errors++; $display("[TB] FAIL b2b_completed: got %0d expected 16", got); end
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL b2b_hready: got %0d bad cycles expected 0", bad); end
    checks++; if (stalls == 0) begin errors++; $display("[TB] FAIL b2b_stalls: got %0d expected nonzero", stalls); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    logic        exp_rdy;
    int w, bad;
    do_reset(32'h0, 32'h8000_0000);
    dmem_xfer(1'b0, 3'd2, 32'h100, 32'h0, rd, w, bad);
    checks++; if (rd !== 32'hDEADBEEF || bad !== 0) begin errors++; $display("[TB] FAIL stalled_read: got %h/%0d expected deadbeef/0", rd, bad); end
    dmem_htrans = 2'b10;
    dmem_haddr  = 32'h204;
    dmem_hwrite = 1'b0;
    @(posedge clk); #1;
    dmem_htrans = 2'b00;
    exp_rdy = dpat[ncyc[4:0]];
    checks++; if (dmem_hready !== exp_rdy || exp_rdy !== 1'b0) begin errors++; $display("[TB] FAIL mid_read_stall: got %b expected 0", dmem_hready); end
    checks++; if (dmem_hrdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL hrdata_hold: got %h expected deadbeef", dmem_hrdata); end
    #2 rst = 1'b1;
    #1;
    checks++; if (dmem_hready !== 1'b1) begin errors++; $display("[TB] FAIL abort_hready: got %b expected 1", dmem_hready); end
    checks++; if (dmem_hrdata !== 32'h0) begin errors++; $display("[TB] FAIL abort_hrdata: got %h expected 0", dmem_hrdata); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_random;
    logic [31:0] rd, a, wd;
    logic [2:0]  sz;
    int w, bad, op;
    for (int round = 0; round < 2; round++) begin
      do_reset(($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
               ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom);
      $display("[TB] random round %0d ipat %h dpat %h", round, ipat, dpat);
      if (round == 0) begin
        for (int i = 0; i < 64; i++) begin
          dwrite(3'd2, 32'h1000 + 4*i, $urandom, bad);
          checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL rand_prefill_handshake: got %0d bad cycles expected 0", bad); end
        end
      end
      for (int i = 0; i < 50; i++) begin
        a  = {16'($urandom_range(0, 16'hEFFF)), 16'h1000 + 16'($urandom_range(0, 255))};
        op = $urandom_range(0, 2);
        if (op == 0) begin
          sz = 3'($urandom_range(0, 2));
          wd = $urandom;
          dwrite(sz, a, wd, bad);
        end else if (op == 1) begin
          dmem_xfer(1'b0, 3'd2, a, 32'h0, rd, w, bad);
          checks++; if (rd !== model_word(a)) begin errors++; $display("[TB] FAIL rand_dmem_read @%h: got %h expected %h", a, rd, model_word(a)); end
        end else begin
          imem_xfer(a, rd, w, bad);
          checks++; if (rd !== model_word(a)) begin errors++; $display("[TB] FAIL rand_imem_read @%h: got %h expected %h", a, rd, model_word(a)); end
        end
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL rand_handshake op %0d @%h: got %0d bad cycles expected 0", op, a, bad); end
      end
    end
  endtask

  task automatic test_irq_addr;
    logic [31:0] rd;
    int w, bad, b2;
    do_reset(32'h0, 32'h0);
    dwrite(3'd2, 32'h0, 32'h5A5A5A5A, bad);
    dmem_xfer(1'b1, 3'd2, 32'hF000_0000, 32'h0000_0003, rd, w, b2);
    bad += b2;
`ifdef SCR1_MEM_IRQ_EN
    checks++; if (irq_lines !== 16'h0003) begin errors++; $display("[TB] FAIL irq_lines: got %h expected 0003", irq_lines); end
    dmem_xfer(1'b0, 3'd2, 32'hF000_0000, 32'h0, rd, w, b2);
    bad += b2;
    checks++; if (rd !== 32'h3) begin errors++; $display("[TB] FAIL irq_readback: got %h expected 00000003", rd); end
    dmem_xfer(1'b0, 3'd2, 32'h0, 32'h0, rd, w, b2);
    bad += b2;
    checks++; if (rd !== 32'h5A5A5A5A) begin errors++; $display("[TB] FAIL irq_array_untouched: got %h expected 5a5a5a5a", rd); end
`else
    model_write(3'd2, 32'hF000_0000, 32'h3);
    dmem_xfer(1'b0, 3'd2, 32'h0, 32'h0, rd, w, b2);
    bad += b2;
    checks++; if (rd !== 32'h3) begin errors++; $display("[TB] FAIL addr_wrap: got %h expected 00000003", rd); end
`endif
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL irq_handshake: got %0d bad cycles expected 0", bad); end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting");
    test_reset();
    test_word_write_fetch();
    test_byte_half();
    test_read_before_write();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_irq_addr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
